module_branch_predictor: RTL

MODULE_BRANCH_PREDICTOR -- requirements
Module: module_branch_predictor

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/module_btb.sv | 44 ++++
 rtl/module_branch_predictor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Branch predictor shared definitions.
// Contents:
//   - bp_ctr_e     : 2-bit saturating direction counter encoding
//   - btb_entry_t  : one BTB entry {valid, tag, target, counter}
//   - BP_ENTRIES_DEFAULT / BP_TAG_W_MAX : sizing constants
//   - ctr_step()   : saturating counter step toward taken / not-taken
package bp_pkg;

    localparam int BP_ENTRIES_DEFAULT = 16;

    // The tag field is sized for the smallest legal table (4 entries -> 28 tag
    // bits). Larger tables zero-extend their shorter tags into it.
    localparam int BP_TAG_W_MAX = 28;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_ctr_e;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        logic [31:0]             target;
        bp_ctr_e                 counter;
    } btb_entry_t;

    // Move one step toward the resolved direction; saturates at both ends.
    function automatic bp_ctr_e ctr_step(input bp_ctr_e c, input logic taken);
        bp_ctr_e r;
        r = c;
        case (c)
            STRONG_NT: r = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   r = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    r = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  r = taken ? STRONG_T : WEAK_T;
            default:   r = WEAK_NT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/module_btb.sv
// Branch target buffer storage.
// Two combinational read ports (fetch lookup and EX-stage lookup), one
// synchronous write port, synchronous active-high reset that clears every
// entry to {valid=0, tag=0, target=0, counter=WEAK_NT}. Reset beats write.
// Ports:
//   clk, rst                 : clock, synchronous reset
//   rd_f_index / rd_f_entry  : fetch read port
//   rd_ex_index / rd_ex_entry: EX read port
//   wr_en, wr_index, wr_entry: write port
module module_btb
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEFAULT,
    localparam int INDEX_W = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_f_index,
    output btb_entry_t         rd_f_entry,
    input  logic [INDEX_W-1:0] rd_ex_index,
    output btb_entry_t         rd_ex_entry,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  btb_entry_t         wr_entry
);

    btb_entry_t mem_reg [ENTRIES];

    // Reads see the stored contents, so a same-cycle write is only visible
    // from the following cycle.
    assign rd_f_entry  = mem_reg[rd_f_index];
    assign rd_ex_entry = mem_reg[rd_ex_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_reg[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: WEAK_NT};
            end
        end else if (wr_en) begin
            mem_reg[wr_index] <= wr_entry;
        end
    end

endmodule

// File: rtl/module_branch_predictor.sv
// Fetch-stage branch predictor: BTB with 2-bit counters, next-PC selection,
// mispredict detection and statistics counters.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   pc_f_i, stall_f_i       : current fetch PC and fetch stall
//   ex_*_i                  : resolved branch/jump from EX plus its fetch-time prediction
//   pcnext_o                : next PC for the PC register
//   pred_taken_f_o / pred_target_f_o : prediction for pc_f_i
//   flush_o                 : mispredict, flush F/D and D/E
//   branch_cnt_o / mispred_cnt_o     : resolved and mispredicted counts since reset
module module_branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEFAULT,
    localparam int INDEX_W = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_f_i,
    input  logic        stall_f_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_is_jump_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic [31:0] pcnext_o,
    output logic        pred_taken_f_o,
    output logic [31:0] pred_target_f_o,
    output logic        flush_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    logic [INDEX_W-1:0]      f_index;
    logic [INDEX_W-1:0]      ex_index;
    logic [BP_TAG_W_MAX-1:0] f_tag;
    logic [BP_TAG_W_MAX-1:0] ex_tag;
    btb_entry_t              f_entry;
    btb_entry_t              ex_entry;
    btb_entry_t              wr_entry;
    logic                    wr_en;
    logic                    f_hit;
    logic                    ex_hit;
    logic                    update;
    logic [31:0]             pc_f_plus4;
    logic [31:0]             ex_pc_plus4;
    logic [31:0]             branch_cnt_reg;
    logic [31:0]             mispred_cnt_reg;

    // Byte-offset bits [1:0] never take part in index or tag.
    assign f_index  = pc_f_i[INDEX_W+1:2];
    assign ex_index = ex_pc_i[INDEX_W+1:2];
    assign f_tag    = BP_TAG_W_MAX'(pc_f_i >> (INDEX_W + 2));
    assign ex_tag   = BP_TAG_W_MAX'(ex_pc_i >> (INDEX_W + 2));

    module_btb #(.ENTRIES(ENTRIES)) u_btb (
        .clk         (clk_i),
        .rst         (rst_i),
        .rd_f_index  (f_index),
        .rd_f_entry  (f_entry),
        .rd_ex_index (ex_index),
        .rd_ex_entry (ex_entry),
        .wr_en       (wr_en),
        .wr_index    (ex_index),
        .wr_entry    (wr_entry)
    );

    assign pc_f_plus4  = pc_f_i + 32'd4;
    assign ex_pc_plus4 = ex_pc_i + 32'd4;

    assign f_hit  = f_entry.valid && (f_entry.tag == f_tag);
    assign ex_hit = ex_entry.valid && (ex_entry.tag == ex_tag);

    assign pred_taken_f_o  = f_hit && (f_entry.counter inside {WEAK_T, STRONG_T});
    assign pred_target_f_o = f_hit ? f_entry.target : pc_f_plus4;

    assign update  = ex_valid_i && (ex_is_branch_i || ex_is_jump_i);
    assign flush_o = update &&
                     ((ex_taken_i != ex_pred_taken_i) ||
                      (ex_taken_i && (ex_target_i != ex_pred_target_i)));

    // Mispredict recovery outranks a fetch stall.
    always_comb begin
        pcnext_o = pc_f_plus4;
        if (flush_o) begin
            pcnext_o = ex_taken_i ? ex_target_i : ex_pc_plus4;
        end else if (stall_f_i) begin
            pcnext_o = pc_f_i;
        end else if (pred_taken_f_o) begin
            pcnext_o = pred_target_f_o;
        end
    end

    // Hit: train the counter (and refresh target when taken).
    // Miss: allocate only on a taken outcome; not-taken misses leave the table alone.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ex_entry;
        if (update) begin
            if (ex_hit) begin
                wr_en            = 1'b1;
                wr_entry.counter = ctr_step(ex_entry.counter, ex_taken_i);
                if (ex_taken_i) begin
                    wr_entry.target = ex_target_i;
                end
            end else if (ex_taken_i) begin
                wr_en            = 1'b1;
                wr_entry.valid   = 1'b1;
                wr_entry.tag     = ex_tag;
                wr_entry.target  = ex_target_i;
                wr_entry.counter = ex_is_jump_i ? STRONG_T : WEAK_T;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (update) begin
                branch_cnt_reg <= branch_cnt_reg + 32'd1;
            end
            if (flush_o) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_reg;
    assign mispred_cnt_o = mispred_cnt_reg;

endmodule
